// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: sync-hunting UART byte framer with XOR checksum, inter-byte timeout and error counting
module uart_frame_decoder #(
  parameter int PAYLOAD_BYTES = 44,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYCLES = 7500000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_new_byte,
  input  logic [7:0]                 rx_byte,
  output logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       payload_valid,
  output logic                       frame_error,
  output logic [7:0]                 error_count,
  output logic                       busy
);
  localparam int IW = $clog2(PAYLOAD_BYTES + 1);
  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [7:0] xsum;
  logic [31:0] timer;
  logic [PAYLOAD_BYTES*8-1:0] staging;
  logic timeout, fail;
  // a byte arriving on the limit cycle wins over the timeout
  assign timeout = state != HUNT && !rx_new_byte && timer == 32'(TIMEOUT_CYCLES - 1);
  assign fail = timeout || (state == CHECK && rx_new_byte && rx_byte != xsum);
  assign busy = state != HUNT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      idx <= '0;
      xsum <= '0;
      timer <= '0;
      staging <= '0;
      payload <= '0;
      payload_valid <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      payload_valid <= 1'b0;
      frame_error <= fail;
      if (fail && error_count != 8'hFF) error_count <= error_count + 8'd1;
      timer <= (state == HUNT || rx_new_byte || timeout) ? '0 : timer + 32'd1;
      if (timeout) state <= HUNT;
      else if (rx_new_byte) begin
        case (state)
          HUNT: if (rx_byte == SYNC_BYTE) begin
            state <= COLLECT;
            idx <= '0;
            xsum <= '0;
          end
          COLLECT: begin
            staging[int'(idx)*8 +: 8] <= rx_byte;
            xsum <= xsum ^ rx_byte;
            idx <= idx + IW'(1);
            if (idx == IW'(PAYLOAD_BYTES - 1)) state <= CHECK;
          end
          CHECK: begin
            state <= HUNT;
            if (rx_byte == xsum) begin
              payload <= staging;
              payload_valid <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: scoreboard bench for uart_frame_decoder with 4-byte payload and 100-cycle timeout
module tb_uart_frame_decoder;
  typedef struct {logic err; logic [31:0] data;} ev_t;
  logic clk = 1'b0, reset = 1'b1, rx_new_byte = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [31:0] payload;
  logic payload_valid, frame_error, busy;
  logic [7:0] error_count;
  int total = 0, bad = 0;
  logic [7:0] seq[$];
  ev_t exp_q[$];
  ev_t ev;

  uart_frame_decoder #(.PAYLOAD_BYTES(4), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_new_byte(rx_new_byte), .rx_byte(rx_byte),
    .payload(payload), .payload_valid(payload_valid), .frame_error(frame_error),
    .error_count(error_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // scoreboard: every valid or error pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && (payload_valid || frame_error)) begin
      total++;
      if (payload_valid && frame_error) begin
        bad++;
        $display("FAIL exclusive: valid=1 err=1 required not both");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: valid=%0b err=%0b payload=%h required none", payload_valid, frame_error, payload);
      end else begin
        ev = exp_q.pop_front();
        if (ev.err !== frame_error || (!ev.err && payload !== ev.data)) begin
          bad++;
          $display("FAIL scoreboard: err=%0b payload=%h required err=%0b payload=%h", frame_error, payload, ev.err, ev.data);
        end
      end
    end
  end

  task send_byte(input logic [7:0] b);
    rx_new_byte = 1'b1;
    rx_byte = b;
    @(negedge clk);
  endtask

  task send_seq();
    foreach (seq[i]) send_byte(seq[i]);
    rx_new_byte = 1'b0;
  endtask

  task idle(input int n);
    rx_new_byte = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (payload !== 32'h0 || payload_valid !== 1'b0 || frame_error !== 1'b0 || error_count !== 8'h0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: payload=%h valid=%0b err=%0b cnt=%0d busy=%0b required all 0", payload, payload_valid, frame_error, error_count, busy);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task test_good_frame();
    exp_q.push_back('{1'b0, 32'h44332211});
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq();
    total++;
    if (payload_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL good_pre: valid=%0b busy=%0b required 0/1", payload_valid, busy);
    end
    send_byte(8'h44);
    rx_new_byte = 1'b0;
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'h44332211 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL good_latency: valid=%0b payload=%h err=%0b required 1/44332211/0", payload_valid, payload, frame_error);
    end
    idle(1);
    total++;
    if (payload_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL good_pulse: valid=%0b busy=%0b required 0/0", payload_valid, busy);
    end
  endtask

  task test_bad_checksum();
    exp_q.push_back('{1'b1, 32'h0});
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_seq();
    total++;
    if (frame_error !== 1'b1 || payload !== 32'h44332211 || error_count !== 8'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bad_checksum: err=%0b payload=%h cnt=%0d busy=%0b required 1/44332211/1/0", frame_error, payload, error_count, busy);
    end
    idle(1);
    total++;
    if (frame_error !== 1'b0) begin
      bad++;
      $display("FAIL bad_pulse: err=%0b required 0", frame_error);
    end
  endtask

  task test_garbage_sync();
    exp_q.push_back('{1'b0, 32'h04030201});
    seq = '{8'h00, 8'hFF, 8'h5A};
    send_seq();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL garbage_busy: busy=%0b required 0", busy);
    end
    seq = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_seq();
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'h04030201 || error_count !== 8'd1) begin
      bad++;
      $display("FAIL garbage_frame: valid=%0b payload=%h cnt=%0d required 1/04030201/1", payload_valid, payload, error_count);
    end
    idle(2);
  endtask

  task test_timeout();
    exp_q.push_back('{1'b1, 32'h0});
    seq = '{8'hA5, 8'h01, 8'h02};
    send_seq();
    idle(99);
    total++;
    if (frame_error !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: err=%0b busy=%0b required 0/1", frame_error, busy);
    end
    idle(1);
    total++;
    if (frame_error !== 1'b1 || busy !== 1'b0 || error_count !== 8'd2) begin
      bad++;
      $display("FAIL timeout_fire: err=%0b busy=%0b cnt=%0d required 1/0/2", frame_error, busy, error_count);
    end
    idle(2);
    exp_q.push_back('{1'b0, 32'h44332211});
    seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_seq();
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'h44332211) begin
      bad++;
      $display("FAIL timeout_recover: valid=%0b payload=%h required 1/44332211", payload_valid, payload);
    end
    idle(2);
  endtask

  task test_timeout_edge();
    exp_q.push_back('{1'b0, 32'h04030201});
    seq = '{8'hA5, 8'h01, 8'h02};
    send_seq();
    idle(99);
    seq = '{8'h03, 8'h04, 8'h04};
    send_seq();
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'h04030201 || error_count !== 8'd2) begin
      bad++;
      $display("FAIL timeout_edge: valid=%0b payload=%h cnt=%0d required 1/04030201/2", payload_valid, payload, error_count);
    end
    idle(2);
  endtask

  task test_embedded_sync();
    exp_q.push_back('{1'b0, 32'hA5A5A5A5});
    seq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    send_seq();
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL embedded_sync: valid=%0b payload=%h required 1/a5a5a5a5", payload_valid, payload);
    end
    idle(2);
  endtask

  task test_back_to_back();
    exp_q.push_back('{1'b0, 32'h04030201});
    exp_q.push_back('{1'b0, 32'h40302010});
    seq = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40};
    send_seq();
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'h40302010 || busy !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back: valid=%0b payload=%h busy=%0b required 1/40302010/0", payload_valid, payload, busy);
    end
    idle(2);
  endtask

  task test_reset_mid_frame();
    seq = '{8'hA5, 8'h01};
    send_seq();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_busy: busy=%0b required 1", busy);
    end
    reset = 1'b1;
    #1;
    total++;
    if (payload !== 32'h0 || error_count !== 8'h0 || busy !== 1'b0 || payload_valid !== 1'b0 || frame_error !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset: payload=%h cnt=%0d busy=%0b required 0/0/0", payload, error_count, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    exp_q.push_back('{1'b0, 32'h0D0C0B0A});
    seq = '{8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h0D};
    send_seq();
    total++;
    if (payload_valid !== 1'b1 || payload !== 32'h0D0C0B0A) begin
      bad++;
      $display("FAIL midframe_recover: valid=%0b payload=%h required 1/0d0c0b0a", payload_valid, payload);
    end
    idle(2);
  endtask

  task test_saturation();
    for (int i = 0; i < 260; i++) begin
      exp_q.push_back('{1'b1, 32'h0});
      seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      send_seq();
      if (i == 253) begin
        total++;
        if (error_count !== 8'd254) begin
          bad++;
          $display("FAIL sat_pre: cnt=%0d required 254", error_count);
        end
      end
    end
    idle(2);
    total++;
    if (error_count !== 8'd255 || payload !== 32'h0D0C0B0A) begin
      bad++;
      $display("FAIL saturation: cnt=%0d payload=%h required 255/0d0c0b0a", error_count, payload);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage_sync();
    test_timeout();
    test_timeout_edge();
    test_embedded_sync();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: left=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
